ex_muldiv_seq: RTL and testbench

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

---
 rtl/ex_muldiv_seq.sv | 131 +++++++++++++
 tb/tb_ex_muldiv_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 cycles, with a one-cycle shortcut for divide-by-zero and signed overflow.
// Stalls the pipeline from the accept cycle through the last iteration. The result is presented for one cycle in DONE.
module ex_muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic        sel_md,
   output logic [31:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [2:0]  op_q;
   logic [31:0] acc_hi, acc_lo, md_b;
   logic        neg_a, neg_b;

   logic        accept, div_zero, div_ovf, shortcut;
   logic        a_sgn, b_sgn, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, short_res;
   logic [32:0] sum, r_sh, diff;
   logic [31:0] hi_nxt, lo_nxt;
   logic [63:0] prod, prod_s;
   logic [31:0] quo_s, rem_s, fin_res;

   // Operand conditioning at accept time.
   always_comb begin
      accept   = (state == S_IDLE) && start && !flush && !reset;
      div_zero = (rs2_val == 32'd0);
      div_ovf  = !op[0] && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
      shortcut = op[2] && (div_zero || div_ovf);
      a_sgn    = op[2] ? !op[0] : ((op == 3'd1) || (op == 3'd2));
      b_sgn    = op[2] ? !op[0] : (op == 3'd1);
      a_neg    = a_sgn && rs1_val[31];
      b_neg    = b_sgn && rs2_val[31];
      a_mag    = a_neg ? (32'd0 - rs1_val) : rs1_val;
      b_mag    = b_neg ? (32'd0 - rs2_val) : rs2_val;
      if (div_zero)
         short_res = op[1] ? rs1_val : 32'hFFFF_FFFF;
      else
         short_res = op[1] ? 32'd0 : 32'h8000_0000;
   end

   // One iteration step. MUL: hi accumulates, lo holds the shifting multiplier.
   // DIV: hi is the partial remainder, lo shifts the dividend out and the quotient in.
   always_comb begin
      sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : 33'd0);
      r_sh = {acc_hi, acc_lo[31]};
      diff = r_sh - {1'b0, md_b};
      if (state == S_MUL) begin
         hi_nxt = sum[32:1];
         lo_nxt = {sum[0], acc_lo[31:1]};
      end else if (!diff[32]) begin
         hi_nxt = diff[31:0];
         lo_nxt = {acc_lo[30:0], 1'b1};
      end else begin
         hi_nxt = r_sh[31:0];
         lo_nxt = {acc_lo[30:0], 1'b0};
      end
      prod    = {hi_nxt, lo_nxt};
      prod_s  = (neg_a ^ neg_b) ? (64'd0 - prod) : prod;
      quo_s   = (neg_a ^ neg_b) ? (32'd0 - lo_nxt) : lo_nxt;
      rem_s   = neg_a ? (32'd0 - hi_nxt) : hi_nxt;
      if (op_q[2])
         fin_res = op_q[1] ? rem_s : quo_s;
      else
         fin_res = (op_q == 3'd0) ? prod_s[31:0] : prod_s[63:32];
   end

   always_comb begin
      state_nxt = state;
      if (reset || flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start) state_nxt = shortcut ? S_DONE : (op[2] ? S_DIV : S_MUL);
            S_MUL,
            S_DIV:  if (cnt == 6'd31) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= 6'd0;
         op_q   <= 3'd0;
         acc_hi <= 32'd0;
         acc_lo <= 32'd0;
         md_b   <= 32'd0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         result <= 32'd0;
      end else if (accept) begin
         cnt    <= 6'd0;
         op_q   <= op;
         neg_a  <= a_neg;
         neg_b  <= b_neg;
         acc_hi <= 32'd0;
         acc_lo <= op[2] ? a_mag : b_mag;
         md_b   <= op[2] ? b_mag : a_mag;
         if (shortcut) result <= short_res;
      end else if (!flush && ((state == S_MUL) || (state == S_DIV))) begin
         acc_hi <= hi_nxt;
         acc_lo <= lo_nxt;
         cnt    <= cnt + 6'd1;
         if (cnt == 6'd31) result <= fin_res;
      end
   end

   always_comb begin
      busy   = (state != S_IDLE) && !reset;
      done   = (state == S_DONE) && !reset;
      sel_md = done;
      stall  = accept || (((state == S_MUL) || (state == S_DIV)) && !reset);
   end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: stimulus pushes expected results and completion cycles,
// an independent monitor pops and compares on every done pulse.
module tb_ex_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  op;
   logic [31:0] rs1_val, rs2_val;
   logic        stall, busy, done, sel_md;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] exp_res[$];
   int          exp_cyc[$];

   ex_muldiv_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .flush(flush), .stall(stall), .busy(busy), .done(done), .sel_md(sel_md), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (exp_res.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            chk("result", result, exp_res.pop_front());
            chk("done_cycle", cyc, exp_cyc.pop_front());
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = s; op = o; rs1_val = a; rs2_val = b;
   endtask

   task automatic op_run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      next_cycle();
      drive(1'b1, o, a, b);
      exp_res.push_back(exp);
      exp_cyc.push_back(cyc + lat);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         chk("stall_busy_phase", {31'd0, stall}, 32'd1);
         next_cycle();
         drive(1'b0, 3'd0, 32'd0, 32'd0);
      end
      @(negedge clk);
      chk("stall_in_done", {31'd0, stall}, 32'd0);
      chk("sel_md_in_done", {31'd0, sel_md}, 32'd1);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("idle_after_done", {30'd0, busy, done}, 32'd0);
   endtask

   // Flush a DIV at cycle t0+10; optionally start a DIVU 100/7 in the very next cycle.
   task automatic flush_run(input logic restart);
      int t0;
      next_cycle();
      drive(1'b1, 3'd4, 32'd1000, 32'd3);
      t0 = cyc;
      next_cycle();
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      while (cyc < t0 + 10) next_cycle();
      flush = 1'b1;
      @(negedge clk);
      chk("stall_in_flush_cycle", {31'd0, stall}, 32'd1);
      next_cycle();
      flush = 1'b0;
      if (restart) begin
         drive(1'b1, 3'd5, 32'd100, 32'd7);
         exp_res.push_back(32'd14);
         exp_cyc.push_back(cyc + 33);
      end
      @(negedge clk);
      chk("busy_after_flush", {31'd0, busy}, 32'd0);
      chk("stall_after_flush", {31'd0, stall}, {31'd0, restart});
      next_cycle();
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (34) next_cycle();
   endtask

   initial begin
      int t0;
      reset = 1'b1; flush = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (2) next_cycle();
      drive(1'b1, 3'd0, 32'd7, 32'd6);
      @(negedge clk);
      chk("reset_outputs", {28'd0, stall, busy, done, sel_md}, 32'd0);
      chk("reset_result", result, 32'd0);
      next_cycle();
      reset = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 32'd0);

      op_run(3'd0, 32'd7,          32'd6,          32'h0000_002A, 33);
      op_run(3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 33);
      op_run(3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33);
      op_run(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
      op_run(3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 33);
      op_run(3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33);
      op_run(3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33);
      op_run(3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,         33);
      op_run(3'd5, 32'd100,        32'd7,          32'd14,        33);
      op_run(3'd7, 32'd100,        32'd7,          32'd2,         33);
      op_run(3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         33);
      op_run(3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
      op_run(3'd6, 32'd5,          32'd0,          32'd5,         1);
      op_run(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
      op_run(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);
      op_run(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1);

      flush_run(1'b0);
      flush_run(1'b1);

      // Flush in IDLE blocks acceptance and stall in the same cycle.
      next_cycle();
      drive(1'b1, 3'd0, 32'd2, 32'd3);
      flush = 1'b1;
      @(negedge clk);
      chk("stall_flush_idle", {31'd0, stall}, 32'd0);
      next_cycle();
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      flush = 1'b0;
      @(negedge clk);
      chk("no_accept_under_flush", {31'd0, busy}, 32'd0);

      // Reset at cycle 20 of a MUL aborts it.
      next_cycle();
      drive(1'b1, 3'd0, 32'd11, 32'd13);
      t0 = cyc;
      next_cycle();
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      while (cyc < t0 + 20) next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_abort_outputs", {28'd0, stall, busy, done, sel_md}, 32'd0);
      chk("reset_abort_result", result, 32'd0);
      op_run(3'd0, 32'd11, 32'd13, 32'd143, 33);

      // Back-to-back: start held through DONE; second op accepted at t0+34, done at t0+67.
      next_cycle();
      drive(1'b1, 3'd0, 32'd3, 32'd5);
      t0 = cyc;
      exp_res.push_back(32'd15);
      exp_cyc.push_back(t0 + 33);
      while (cyc < t0 + 34) next_cycle();
      drive(1'b1, 3'd0, 32'd9, 32'd9);
      exp_res.push_back(32'd81);
      exp_cyc.push_back(t0 + 67);
      @(negedge clk);
      chk("b2b_idle_at_34", {30'd0, busy, stall}, 32'd1);
      next_cycle();
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      while (cyc < t0 + 70) next_cycle();

      chk("all_expected_done", exp_res.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
